circ_queue: RTL and testbench

Parametrised circular FIFO built on a synchronous dual-port RAM. It is the next-generation replacement for the fixed 384×8 capture RAM. Width, depth (including non-power-of-2) and overflow policy are parameters. It maintains its own head/tail pointers, occupancy count and full/empty/overflow flags, and allows simultaneous push and pop, which the old write-priority RAM could not do. It sits between a sampling front end (pusher) and a readout/UART engine (popper).

---
 rtl/circ_queue_pkg.sv | 17 +
 rtl/circ_queue_if.sv | 31 +++
 rtl/circ_queue_dp_ram.sv | 38 +++
 rtl/circ_queue.sv | 127 ++++++++++++
 tb/tb_circ_queue.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/circ_queue_pkg.sv
// Shared types and helpers for the circular queue.
package circ_queue_pkg;

    // Kind of occupancy change accepted in one cycle.
    typedef enum logic [1:0] {
        OpIdle,
        OpPush,
        OpPop,
        OpBoth
    } op_e;

    // Increment a pointer that wraps at depth-1 back to 0 (no power-of-2 assumption).
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/circ_queue_if.sv
// Push/pop/status bundle between the queue and its pusher/popper.
interface circ_queue_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 384
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] wdata;
    logic              rd_req;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;

    // User side: issues push/pop/clear, observes data and status.
    modport master (
        output clr, wr_en, wdata, rd_req,
        input  rdata, rd_valid, count, empty, full, overflow
    );

    // Queue side.
    modport slave (
        input  clr, wr_en, wdata, rd_req,
        output rdata, rd_valid, count, empty, full, overflow
    );

endinterface

// File: rtl/circ_queue_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
module circ_queue_dp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 384,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; sees the pre-write word on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/circ_queue.sv
// Parametrised circular FIFO with drop-or-evict overflow policy.
module circ_queue
    import circ_queue_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 384,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    circ_queue_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              rd_valid_q, rd_valid_d;

    logic pop_acc;
    logic push_acc;
    logic lost;
    logic evict;
    logic ram_we;
    op_e  op;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
        return ADDR_W'(wrap_inc(32'(ptr), DEPTH));
    endfunction

    // Decide what is accepted this cycle; clr blocks every other operation.
    always_comb begin
        pop_acc  = !bus.clr && bus.rd_req && !empty_q;
        push_acc = !bus.clr && bus.wr_en && (!full_q || pop_acc);
        // Push against a full queue with no pop to make room.
        lost     = !bus.clr && bus.wr_en && full_q && !pop_acc;
        evict    = lost && (OVERWRITE != 0);
        ram_we   = push_acc || evict;
        unique case ({push_acc, pop_acc})
            2'b10:   op = OpPush;
            2'b01:   op = OpPop;
            2'b11:   op = OpBoth;
            default: op = OpIdle;
        endcase
    end

    // Next-state for pointers, occupancy and flags.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_valid_d = pop_acc;
        if (bus.clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (ram_we) begin
                tail_d = ptr_inc(tail_q);
            end
            // An eviction discards the oldest word, so head follows tail.
            if (pop_acc || evict) begin
                head_d = ptr_inc(head_q);
            end
            unique case (op)
                OpPush:  count_d = count_q + 1'b1;
                OpPop:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (lost) begin
                ovf_d = 1'b1;
            end
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    circ_queue_dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (tail_q),
        .wdata (bus.wdata),
        .re    (pop_acc),
        .raddr (head_q),
        .rdata (bus.rdata)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_circ_queue.sv
// Bench for circ_queue: three instances (5/drop, 5/evict, 384/drop) share one stimulus stream.
module tb_circ_queue;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    circ_queue_if #(.DATA_W(8), .DEPTH(5))   bus0 ();
    circ_queue_if #(.DATA_W(8), .DEPTH(5))   bus1 ();
    circ_queue_if #(.DATA_W(8), .DEPTH(384)) bus2 ();

    circ_queue #(.DATA_W(8), .DEPTH(5), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    circ_queue #(.DATA_W(8), .DEPTH(5), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    circ_queue #(.DATA_W(8), .DEPTH(384), .OVERWRITE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int failures = 0;

    int dep [NI] = '{5, 5, 384};
    int ow  [NI] = '{0, 1, 0};

    // Reference model and scoreboard per instance.
    logic [7:0] mq  [NI][$];
    logic [7:0] sb  [NI][$];
    logic       movf [NI];
    logic       mrv  [NI];
    logic [7:0] mrd  [NI];

    // Sampled DUT outputs.
    int         a_count [NI];
    logic       a_empty [NI];
    logic       a_full  [NI];
    logic       a_ovf   [NI];
    logic       a_rv    [NI];
    logic [7:0] a_rdata [NI];

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         cnt;
        logic       e;
        logic       f;
        logic       ov;
        logic       rv;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic w, input logic [7:0] d, input logic r, input logic c,
                       input int cnt, input logic e, input logic f, input logic ov,
                       input logic rv, input logic [7:0] rd);
        vec_t v;
        v = '{w, d, r, c, cnt, e, f, ov, rv, rd};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h", name, i, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        bus0.wr_en = w; bus0.wdata = d; bus0.rd_req = r; bus0.clr = c;
        bus1.wr_en = w; bus1.wdata = d; bus1.rd_req = r; bus1.clr = c;
        bus2.wr_en = w; bus2.wdata = d; bus2.rd_req = r; bus2.clr = c;
    endtask

    task automatic sample();
        a_count[0] = int'(bus0.count); a_empty[0] = bus0.empty; a_full[0] = bus0.full;
        a_ovf[0] = bus0.overflow; a_rv[0] = bus0.rd_valid; a_rdata[0] = bus0.rdata;
        a_count[1] = int'(bus1.count); a_empty[1] = bus1.empty; a_full[1] = bus1.full;
        a_ovf[1] = bus1.overflow; a_rv[1] = bus1.rd_valid; a_rdata[1] = bus1.rdata;
        a_count[2] = int'(bus2.count); a_empty[2] = bus2.empty; a_full[2] = bus2.full;
        a_ovf[2] = bus2.overflow; a_rv[2] = bus2.rd_valid; a_rdata[2] = bus2.rdata;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            sb[i].delete();
            movf[i] = 1'b0;
            mrv[i]  = 1'b0;
            mrd[i]  = 8'h00;
        end
    endtask

    // Advance the model by one accepted-edge worth of behaviour.
    task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic c);
        for (int i = 0; i < NI; i++) begin
            logic pop;
            logic full;
            logic [7:0] junk;
            if (c) begin
                mq[i].delete();
                movf[i] = 1'b0;
                mrv[i]  = 1'b0;
            end else begin
                pop  = r && (mq[i].size() != 0);
                full = (mq[i].size() == dep[i]);
                mrv[i] = pop;
                if (pop) begin
                    mrd[i] = mq[i].pop_front();
                    sb[i].push_back(mrd[i]);
                end
                if (w) begin
                    if (!full || pop) begin
                        mq[i].push_back(d);
                    end else begin
                        movf[i] = 1'b1;
                        if (ow[i] != 0) begin
                            junk = mq[i].pop_front();
                            mq[i].push_back(d);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("count", i, a_count[i], mq[i].size());
            chk("empty", i, int'(a_empty[i]), int'(mq[i].size() == 0));
            chk("full", i, int'(a_full[i]), int'(mq[i].size() == dep[i]));
            chk("overflow", i, int'(a_ovf[i]), int'(movf[i]));
            chk("rd_valid", i, int'(a_rv[i]), int'(mrv[i]));
            chk("rdata", i, int'(a_rdata[i]), int'(mrd[i]));
            if (a_rv[i]) begin
                if (sb[i].size() == 0) chk("sb_depth", i, 0, 1);
                else chk("sb_data", i, int'(a_rdata[i]), int'(sb[i].pop_front()));
            end
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        drive(w, d, r, c);
        model_step(w, d, r, c);
        @(posedge clk);
        #1;
        sample();
        check_all();
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();

        // Fill/drain, pop on empty, drop on full, then clr (expectations for instance 0).
        for (int k = 0; k < 5; k++)
            add(1, 8'(8'h10 + k), 0, 0, k + 1, 0, k == 4, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++)
            add(0, 8'h00, 1, 0, 4 - k, k == 4, 0, 0, 1, 8'(8'h10 + k));
        add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h14);
        for (int k = 0; k < 6; k++)
            add(1, 8'(8'hA0 + k), 0, 0, (k < 5) ? k + 1 : 5, 0, k >= 4, k == 5, 0, 8'h14);
        for (int k = 0; k < 5; k++)
            add(0, 8'h00, 1, 0, 4 - k, k == 4, 0, 1, 1, 8'(8'hA0 + k));
        add(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'hA4);

        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        sample();
        check_all();

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].w, tbl[k].d, tbl[k].r, tbl[k].c);
            chk("tbl_count", k, a_count[0], tbl[k].cnt);
            chk("tbl_empty", k, int'(a_empty[0]), int'(tbl[k].e));
            chk("tbl_full", k, int'(a_full[0]), int'(tbl[k].f));
            chk("tbl_ovf", k, int'(a_ovf[0]), int'(tbl[k].ov));
            chk("tbl_rv", k, int'(a_rv[0]), int'(tbl[k].rv));
            chk("tbl_rdata", k, int'(a_rdata[0]), int'(tbl[k].rd));
        end

        // Evict on full: OVERWRITE instance keeps the newest five.
        step(0, 8'h00, 0, 1);
        for (int k = 0; k < 7; k++) step(1, 8'(8'hA0 + k), 0, 0);
        chk("evict_count", 1, a_count[1], 5);
        chk("evict_ovf", 1, int'(a_ovf[1]), 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 8'h00, 1, 0);
            chk("evict_data", 1, int'(a_rdata[1]), 8'hA2 + k);
            chk("drop_data", 0, int'(a_rdata[0]), 8'hA0 + k);
        end

        // Push + pop on empty: push only.
        step(0, 8'h00, 0, 1);
        step(1, 8'h55, 1, 0);
        chk("pp_empty_rv", 0, int'(a_rv[0]), 0);
        chk("pp_empty_count", 0, a_count[0], 1);
        step(0, 8'h00, 1, 0);
        chk("pp_empty_data", 0, int'(a_rdata[0]), 8'h55);

        // Push + pop on full: oldest returned, new word lands last.
        step(0, 8'h00, 0, 1);
        for (int k = 0; k < 5; k++) step(1, 8'(8'hB0 + k), 0, 0);
        step(1, 8'h77, 1, 0);
        chk("pp_full_data", 0, int'(a_rdata[0]), 8'hB0);
        chk("pp_full_count", 0, a_count[0], 5);
        for (int k = 0; k < 5; k++) step(0, 8'h00, 1, 0);
        chk("pp_full_last", 0, int'(a_rdata[0]), 8'h77);

        // Long stream across several pointer wraps, with a clr in the middle.
        step(0, 8'h00, 0, 1);
        for (int n = 0; n < 1000; n++) begin
            step(1, 8'(n), 0, 0);
            if (n == 500) begin
                step(0, 8'h00, 0, 1);
                chk("clr_count", 2, a_count[2], 0);
                chk("clr_empty", 2, int'(a_empty[2]), 1);
            end
            step(0, 8'h00, 1, 0);
            if (a_count[2] > 1) chk("stream_count_max", 2, a_count[2], 1);
        end

        // Async reset while a pop is in flight.
        step(0, 8'h00, 0, 1);
        for (int k = 0; k < 6; k++) step(1, 8'(8'hC0 + k), 0, 0);
        step(0, 8'h00, 1, 0);
        chk("pre_rst_rv", 0, int'(a_rv[0]), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        sample();
        model_reset();
        for (int i = 0; i < NI; i++) begin
            chk("rst_rv", i, int'(a_rv[i]), 0);
            chk("rst_count", i, a_count[i], 0);
            chk("rst_ovf", i, int'(a_ovf[i]), 0);
            chk("rst_empty", i, int'(a_empty[i]), 1);
            chk("rst_rdata", i, int'(a_rdata[i]), 0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 8'h00, 1, 0);
        step(1, 8'hD0, 0, 0);
        step(0, 8'h00, 1, 0);
        chk("post_rst_data", 0, int'(a_rdata[0]), 8'hD0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
